// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/execute sequencer: FSM encoding and PC constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/next_pc_sel.sv
// Priority mux for the PC that follows a completed instruction.
// Exception beats halt beats jump beats branch beats sequential; a misaligned
// jump/branch target is folded into the trap path.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int unsigned       XLEN        = 32,
  parameter logic [XLEN-1:0]   TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            exception_i,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] npc_o,
  output logic            trap_o,
  output logic            retire_o,
  output logic            halt_o
);

  // Resolve next PC, trap and retire flags in strict priority order.
  always_comb begin
    npc_o    = pc_i + XLEN'(PC_INC);
    trap_o   = 1'b0;
    retire_o = 1'b1;
    halt_o   = 1'b0;
    if (exception_i) begin
      npc_o    = TRAP_VECTOR;
      trap_o   = 1'b1;
      retire_o = 1'b0;
    end else if (halt_i) begin
      npc_o  = pc_i;
      halt_o = 1'b1;
    end else if (jump_i) begin
      if (|jump_target_i[1:0]) begin
        npc_o    = TRAP_VECTOR;
        trap_o   = 1'b1;
        retire_o = 1'b0;
      end else begin
        npc_o = jump_target_i;
      end
    end else if (branch_taken_i) begin
      if (|branch_target_i[1:0]) begin
        npc_o    = TRAP_VECTOR;
        trap_o   = 1'b1;
        retire_o = 1'b0;
      end else begin
        npc_o = branch_target_i;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute handshake controller.
// BOOT gives one idle cycle after reset, FETCH holds the request until ack,
// EXEC waits for instr_done and then commits the selected next PC.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            startin_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            instr_done,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            exception,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic [31:0]     instret,
  output logic [1:0]      state
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, epc_q;
  logic [31:0]     instret_q;
  logic [XLEN-1:0] npc;
  logic            trap, retire, halt_sel, done_fire;

  // instr_done only means anything while executing
  assign done_fire = (state_q == ST_EXEC) && instr_done;

  next_pc_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_sel (
    .pc_i            (pc_q),
    .exception_i     (exception),
    .halt_i          (halt),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .npc_o           (npc),
    .trap_o          (trap),
    .retire_o        (retire),
    .halt_o          (halt_sel)
  );

  // FSM state register
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) state_q <= ST_BOOT;
    else            state_q <= state_d;
  end

  // FSM next-state logic; HALT is terminal until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  if (instr_done) state_d = halt_sel ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // FSM outputs, decoded straight from registers so reset drops the request at once
  always_comb begin
    imem_req  = (state_q == ST_FETCH);
    imem_addr = pc_q;
    state     = state_q;
  end

  // PC, exception PC and retire counter update on instruction completion
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      instret_q <= '0;
    end else if (done_fire) begin
      pc_q <= npc;
      if (trap)   epc_q     <= pc_q;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by a randomized run
// against a transaction-level model of the PC/epc/instret rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        startin_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, instr_done = 1'b0;
  logic [31:0] imem_addr, pc, epc, instret;
  logic        branch_taken = 1'b0, jump = 1'b0, exception = 1'b0, halt = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [1:0]  state;

  int ncheck = 0;
  int nfail  = 0;

  // model state
  logic [31:0] m_pc, m_epc, m_instret;
  int          m_state; // 0 BOOT, 1 FETCH, 2 EXEC, 3 HALT

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk           (clk),
    .startin_n     (startin_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .instr_done    (instr_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .halt          (halt),
    .pc            (pc),
    .epc           (epc),
    .instret       (instret),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ctl;
    branch_taken  = 1'($urandom);
    jump          = 1'($urandom);
    exception     = 1'($urandom);
    halt          = 1'($urandom);
    branch_target = $urandom;
    jump_target   = $urandom;
  endtask

  task automatic clr_ctl;
    {branch_taken, jump, exception, halt} = '0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},      pc,      m_pc);
    chk({tag, ".epc"},     epc,     m_epc);
    chk({tag, ".instret"}, instret, m_instret);
    chk({tag, ".state"},   32'(state), 32'(m_state));
  endtask

  // Assert reset asynchronously a few ns after an edge, check it took
  // effect immediately, release, then check one BOOT cycle before FETCH.
  task automatic do_reset;
    #3;
    startin_n = 1'b0;
    #1;
    m_pc = RV; m_epc = '0; m_instret = '0; m_state = 0;
    chk("rst.req", 32'(imem_req), 32'd0);
    chk_all("rst");
    #2;
    imem_ack = 1'b0; instr_done = 1'b0; clr_ctl();
    startin_n = 1'b1;
    chk("boot.state", 32'(state), 32'd0);
    tick();
    m_state = 1;
    chk("boot.next", 32'(state), 32'd1);
  endtask

  // FETCH with ack after 'dly' cycles; spurious instr_done is driven meanwhile.
  task automatic fetch(input int dly);
    for (int i = 0; i <= dly; i++) begin
      chk("fetch.req",  32'(imem_req), 32'd1);
      chk("fetch.addr", imem_addr, m_pc);
      chk("fetch.state", 32'(state), 32'd1);
      instr_done = 1'($urandom);
      rand_ctl();
      imem_ack = (i == dly);
      tick();
    end
    imem_ack = 1'b0; instr_done = 1'b0; clr_ctl();
    m_state = 2;
    chk("fetch.toexec", 32'(state), 32'd2);
  endtask

  // EXEC: 'dly' cycles of ignored garbage control, then instr_done with the given controls.
  task automatic exec(input int dly, input bit exc, input bit hlt,
                      input bit jmp, input logic [31:0] jt,
                      input bit br,  input logic [31:0] bt);
    logic [31:0] tgt;
    for (int i = 0; i < dly; i++) begin
      rand_ctl();
      imem_ack = 1'($urandom);
      tick();
      chk("exec.wait.state", 32'(state), 32'd2);
      chk("exec.wait.pc", pc, m_pc);
      chk("exec.wait.req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    exception = exc; halt = hlt; jump = jmp; jump_target = jt;
    branch_taken = br; branch_target = bt;
    instr_done = 1'b1;
    // reference model of instruction completion
    if (exc) begin
      m_epc = m_pc; m_pc = TV; m_state = 1;
    end else if (hlt) begin
      m_instret = m_instret + 1; m_state = 3;
    end else begin
      tgt = jmp ? jt : (br ? bt : m_pc + 4);
      if ((jmp || br) && (tgt % 4 != 0)) begin
        m_epc = m_pc; m_pc = TV;
      end else begin
        m_pc = tgt; m_instret = m_instret + 1;
      end
      m_state = 1;
    end
    tick();
    instr_done = 1'b0; clr_ctl();
    chk_all("exec.done");
  endtask

  task automatic seq(input int fd, input int ed);
    fetch(fd);
    exec(ed, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); instr_done = 1'($urandom); rand_ctl();
      tick();
      chk("halt.req", 32'(imem_req), 32'd0);
      chk_all("halt");
    end
    imem_ack = 1'b0; instr_done = 1'b0; clr_ctl();
  endtask

  initial begin
    int fd, ed, r;
    bit exc, hlt, jmp, br;
    logic [31:0] jt, bt;

    tick();
    // 1: reset then three sequential instructions, zero-wait handshakes
    do_reset();
    seq(0, 0); seq(0, 0); seq(0, 0);
    chk("t1.instret", instret, 32'd3);
    // 2: ack delayed 3 cycles -> request held 4 cycles at a stable address
    fetch(3);
    exec(2, 0, 0, 0, '0, 0, '0);
    // 3: jump beats branch
    fetch(0);
    exec(0, 0, 0, 1, 32'h100, 1, 32'h40);
    chk("t3.pc", pc, 32'h100);
    // 4: misaligned jump traps
    fetch(0);
    exec(0, 0, 0, 1, 32'h22, 0, '0);
    chk("t4.pc", pc, TV);
    chk("t4.epc", epc, 32'h100);
    // misaligned branch traps too
    fetch(0);
    exec(0, 0, 0, 0, '0, 1, 32'h41);
    chk("t4b.epc", epc, TV);
    // PC wraps modulo 2^32
    fetch(0);
    exec(0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0);
    seq(1, 0);
    chk("wrap.pc", pc, 32'h0);
    // 5: exception wins over halt, then halt alone
    fetch(0);
    exec(0, 0, 0, 1, 32'h20, 0, '0);
    fetch(0);
    exec(0, 1, 1, 0, '0, 0, '0);
    chk("t5.pc", pc, TV);
    chk("t5.epc", epc, 32'h20);
    chk("t5.state", 32'(state), 32'd1);
    fetch(0);
    exec(1, 0, 1, 0, '0, 0, '0);
    chk("t5.halt", 32'(state), 32'd3);
    hold_halt(10);
    // 6: reset mid-FETCH at pc=0x40
    do_reset();
    fetch(0);
    exec(0, 0, 0, 1, 32'h40, 0, '0);
    chk("t6.req", 32'(imem_req), 32'd1);
    chk("t6.addr", imem_addr, 32'h40);
    do_reset();
    chk("t6.addr0", imem_addr, RV);

    // randomized run
    for (int n = 0; n < 200; n++) begin
      fd = $urandom_range(0, 3);
      ed = $urandom_range(0, 2);
      r  = $urandom_range(0, 99);
      exc = (r < 10);
      hlt = ($urandom_range(0, 99) < 4);
      jmp = ($urandom_range(0, 99) < 25);
      br  = ($urandom_range(0, 99) < 30);
      jt = $urandom; bt = $urandom;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      fetch(fd);
      exec(ed, exc, hlt, jmp, jt, br, bt);
      if (m_state == 3) begin
        hold_halt(3);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
